barret_reduce_pipe: RTL and testbench

Parametrised, pipelined Barrett modular reducer. Reduces a 2K-bit operand modulo a fixed K-bit modulus Q and always returns a fully reduced residue in [0, Q).
- Accepts one operand per cycle through a valid/ready handshake with full backpressure.
- Carries an opaque sideband tag alongside each operand.
- Sits after the polynomial/NTT multipliers, where products must be reduced before the next butterfly stage.

---
 rtl/barret_reduce_pipe_if.sv | 25 ++
 rtl/barret_reduce_pipe.sv | 125 ++++++++++++
 tb/tb_barret_reduce_pipe.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barret_reduce_pipe_if.sv
// Valid/ready operand and result channels of the Barrett reducer.
// The reducer takes the slave side; the producer/consumer pair takes the master side.
interface barret_reduce_pipe_if #(
  parameter int unsigned K     = 11,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2*K-1:0]   in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [K-1:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/barret_reduce_pipe.sv
// Three-stage pipelined Barrett reducer: out_data = in_data mod Q for any 2K-bit operand,
// with valid/ready backpressure on both sides and an opaque tag carried alongside.
module barret_reduce_pipe #(
  parameter int unsigned Q     = 1907,
  parameter int unsigned K     = 11,
  parameter int unsigned TAG_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  barret_reduce_pipe_if.slave bus
);
  localparam int unsigned DIN_W = 2 * K;
  localparam int unsigned PW    = 2 * K + 1;
  localparam int unsigned RW    = K + 2;
  localparam logic [PW-1:0] MU  = PW'((64'd1 << DIN_W) / 64'(Q));
  localparam logic [RW-1:0] Q1  = RW'(Q);
  localparam logic [RW-1:0] Q2  = RW'(2 * Q);
  localparam logic [RW-1:0] Q3  = RW'(3 * Q);

  if ((Q <= (1 << (K - 1))) || (Q >= (1 << K))) begin : g_bad_modulus
    $error("barret_reduce_pipe: Q must lie strictly between 2^(K-1) and 2^K");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("barret_reduce_pipe: TAG_W must be at least 1");
  end

  logic             v1, v2, v3;
  logic             ready1, ready2, ready3;
  logic [PW-1:0]    p1;
  logic [DIN_W-1:0] a1;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic [RW-1:0]    r2;
  logic [K-1:0]     res3;

  logic [K-1:0]     q1;
  logic [PW-1:0]    p_next;
  logic [K:0]       t2;
  logic [PW-1:0]    tq;
  logic [RW-1:0]    r_next;
  logic [K-1:0]     res_next;

  // Ready ripples back combinationally from out_ready so empty stages fill under a stall.
  assign ready3       = !v3 || bus.out_ready;
  assign ready2       = !v2 || ready3;
  assign ready1       = !v1 || ready2;
  assign bus.in_ready = ready1;

  assign bus.out_valid = v3;
  assign bus.out_data  = res3;
  assign bus.out_tag   = tag3;

  always_comb begin
    q1     = bus.in_data[DIN_W-1:K];
    p_next = PW'(q1) * MU;
  end

  // Only the low RW bits of a - t*Q are needed since the true difference is below 4Q.
  always_comb begin
    t2     = (K + 1)'(p1 >> K);
    tq     = PW'(t2) * PW'(Q);
    r_next = RW'({1'b0, a1} - tq);
  end

  always_comb begin
    res_next = K'(r2);
    if (r2 >= Q3) begin
      res_next = K'(r2 - Q3);
    end else if (r2 >= Q2) begin
      res_next = K'(r2 - Q2);
    end else if (r2 >= Q1) begin
      res_next = K'(r2 - Q1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      p1   <= '0;
      a1   <= '0;
      tag1 <= '0;
    end else if (ready1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        p1   <= p_next;
        a1   <= bus.in_data;
        tag1 <= bus.in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      r2   <= '0;
      tag2 <= '0;
    end else if (ready2) begin
      v2 <= v1;
      if (v1) begin
        r2   <= r_next;
        tag2 <= tag1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      res3 <= '0;
      tag3 <= '0;
    end else if (ready3) begin
      v3 <= v2;
      if (v2) begin
        res3 <= res_next;
        tag3 <= tag2;
      end
    end
  end

  property p_out_hold;
    @(posedge clk) disable iff (!rst_n)
      (v3 && !bus.out_ready) |=> (v3 && $stable(res3) && $stable(tag3));
  endproperty
  a_out_hold: assert property (p_out_hold);

endmodule

// File: tb/tb_barret_reduce_pipe.sv
// Bench for barret_reduce_pipe: default (Q=1907,K=11) and re-parametrised (Q=3329,K=12)
// instances checked against a queue model that computes a % Q at acceptance.
module tb_barret_reduce_pipe;
  localparam int unsigned QA  = 1907;
  localparam int unsigned KA  = 11;
  localparam int unsigned QB  = 3329;
  localparam int unsigned KB  = 12;
  localparam int unsigned TW  = 4;
  localparam int unsigned DWA = 2 * KA;
  localparam int unsigned DWB = 2 * KB;

  typedef struct {
    int unsigned res;
    int unsigned tag;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  barret_reduce_pipe_if #(.K(KA), .TAG_W(TW)) a_if ();
  barret_reduce_pipe_if #(.K(KB), .TAG_W(TW)) b_if ();

  barret_reduce_pipe #(.Q(QA), .K(KA), .TAG_W(TW)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  barret_reduce_pipe #(.Q(QB), .K(KB), .TAG_W(TW)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  bit          lat_exact = 1'b1;
  exp_t        qa[$];
  exp_t        qb[$];
  bit          hold_v[2];
  int unsigned hold_d[2];
  int unsigned hold_t[2];
  bit          seen[2];
  bit          acc[2];
  bit          got[2];
  int unsigned got_d[2];
  int unsigned got_t[2];
  bit          last_ir[2];

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each accepted operand queues (a mod Q, tag); each output is checked against the head.
  task automatic mon(input bit s, input bit iv, input bit ir, input int unsigned id,
                     input int unsigned it, input bit ov, input bit orr,
                     input int unsigned od, input int unsigned ot);
    exp_t e;
    int unsigned q = s ? QB : QA;
    int unsigned depth = s ? qb.size() : qa.size();
    got[s] = 1'b0;
    last_ir[s] = ir;
    if (hold_v[s]) begin
      chk("stall_valid", ov, 1);
      if (ov) begin
        chk("stall_data", od, hold_d[s]);
        chk("stall_tag", ot, hold_t[s]);
      end
    end
    if (ov) begin
      if (depth == 0) begin
        chk("spurious_out_valid", ov, 0);
      end else begin
        e = s ? qb[0] : qa[0];
        if (!seen[s]) begin
          seen[s] = 1'b1;
          if (lat_exact) chk("latency", cyc - e.cyc, 3);
          else chk("latency_min", (cyc - e.cyc) >= 3, 1);
        end
        chk(s ? "b_data" : "a_data", od, e.res);
        chk(s ? "b_tag" : "a_tag", ot, e.tag);
        if (orr) begin
          if (s) void'(qb.pop_front());
          else void'(qa.pop_front());
          seen[s]  = 1'b0;
          got[s]   = 1'b1;
          got_d[s] = od;
          got_t[s] = ot;
        end
      end
    end
    hold_v[s] = ov && !orr;
    hold_d[s] = od;
    hold_t[s] = ot;
    acc[s] = iv && ir;
    if (iv && ir) begin
      e.res = id % q;
      e.tag = it;
      e.cyc = cyc;
      if (s) qb.push_back(e);
      else qa.push_back(e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    mon(0, a_if.in_valid, a_if.in_ready, 32'(a_if.in_data), 32'(a_if.in_tag),
        a_if.out_valid, a_if.out_ready, 32'(a_if.out_data), 32'(a_if.out_tag));
    mon(1, b_if.in_valid, b_if.in_ready, 32'(b_if.in_data), 32'(b_if.in_tag),
        b_if.out_valid, b_if.out_ready, 32'(b_if.out_data), 32'(b_if.out_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input bit v, input int unsigned d, input int unsigned t,
                       input bit orr);
    if (s) begin
      b_if.in_valid  = v;
      b_if.in_data   = DWB'(d);
      b_if.in_tag    = TW'(t);
      b_if.out_ready = orr;
    end else begin
      a_if.in_valid  = v;
      a_if.in_data   = DWA'(d);
      a_if.in_tag    = TW'(t);
      a_if.out_ready = orr;
    end
  endtask

  function automatic int unsigned rand_op(input bit s);
    int unsigned m = s ? 32'h00ff_ffff : 32'h003f_ffff;
    int unsigned q = s ? QB : QA;
    case ($urandom_range(0, 15))
      0:       return m;
      1:       return q * q - 1;
      2:       return q * $urandom_range(0, q);
      default: return $urandom & m;
    endcase
  endfunction

  task automatic drain(input bit s);
    int n = 0;
    while (((s ? qb.size() : qa.size()) > 0) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", s ? qb.size() : qa.size(), 0);
  endtask

  task automatic directed(input bit s, input int unsigned a, input int unsigned t,
                          input int unsigned exp_d);
    int n = 0;
    lat_exact = 1'b1;
    drive(s, 1, a, t, 1);
    do begin
      tick();
      n++;
    end while (!acc[s] && n < 20);
    drive(s, 0, 0, 0, 1);
    while (!got[s] && n < 40) begin
      tick();
      n++;
    end
    if (!got[s]) begin
      chk("dir_timeout", got[s], 1);
    end else begin
      chk("dir_data", got_d[s], exp_d);
      chk("dir_tag", got_t[s], t);
    end
  endtask

  task automatic run(input bit s, input int n, input bit rnd);
    int unsigned cur_d, cur_t;
    int k = 0;
    int guard = 0;
    bit v;
    lat_exact = !rnd;
    cur_d = rand_op(s);
    cur_t = $urandom_range(0, 15);
    while (k < n && guard < 8 * n + 50) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive(s, v, v ? cur_d : $urandom, cur_t, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      tick();
      if (!rnd) chk("stream_in_ready", last_ir[s], 1);
      if (acc[s]) begin
        k++;
        cur_d = rand_op(s);
        cur_t = $urandom_range(0, 15);
      end
      guard++;
    end
    chk("run_accepted", k, n);
    drive(s, 0, 0, 0, 1);
    drain(s);
  endtask

  initial begin
    int unsigned bp_d[5] = '{100000, 4194303, 3813, 7, 3636648};
    int unsigned rs_d[3] = '{1906, 3813, 4194303};
    int k;
    int n;

    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    #12;
    chk("rst_a_valid", a_if.out_valid, 0);
    chk("rst_a_data", a_if.out_data, 0);
    chk("rst_a_tag", a_if.out_tag, 0);
    chk("rst_b_valid", b_if.out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_a_in_ready", a_if.in_ready, 1);
    chk("rst_b_in_ready", b_if.in_ready, 1);

    directed(0, 0, 4'h1, 0);
    directed(0, 1906, 4'h2, 1906);
    directed(0, 1907, 4'h3, 0);
    directed(0, 4194303, 4'hA, 810);
    directed(0, 3636648, 4'h5, 1906);
    directed(0, 3813, 4'h3, 1906);
    directed(0, 3814, 4'hC, 0);
    directed(1, 0, 4'h6, 0);
    directed(1, 3329, 4'h7, 0);
    directed(1, 16777215, 4'h8, 2384);

    run(0, 1000, 0);

    // Backpressure: five operands offered against a stalled sink.
    lat_exact = 1'b0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, bp_d[k], k + 1, 0);
      tick();
      if (acc[0]) k++;
    end
    chk("bp_accepted", k, 3);
    chk("bp_in_ready", a_if.in_ready, 0);
    chk("bp_out_valid", a_if.out_valid, 1);
    n = 0;
    while (k < 5 && n < 40) begin
      drive(0, 1, bp_d[k], k + 1, 1);
      tick();
      if (acc[0]) k++;
      n++;
    end
    chk("bp_rest", k, 5);
    drive(0, 0, 0, 0, 1);
    drain(0);

    run(0, 2000, 1);
    run(1, 3000, 0);
    run(1, 1000, 1);

    // Asynchronous reset with three operands in flight.
    lat_exact = 1'b0;
    k = 0;
    n = 0;
    while (k < 3 && n < 20) begin
      drive(0, 1, rs_d[k], 15 - k, 0);
      tick();
      if (acc[0]) k++;
      n++;
    end
    drive(0, 0, 0, 0, 0);
    chk("rst_fill", k, 3);
    chk("rst_pre_valid", a_if.out_valid, 1);
    chk("rst_pre_data", a_if.out_data, 1906);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", a_if.out_valid, 0);
    chk("arst_data", a_if.out_data, 0);
    chk("arst_tag", a_if.out_tag, 0);
    qa.delete();
    qb.delete();
    for (int i = 0; i < 2; i++) begin
      hold_v[i] = 1'b0;
      seen[i]   = 1'b0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1);
    chk("post_rst_in_ready", a_if.in_ready, 1);
    directed(0, 9542, 4'h9, 7);
    for (int i = 0; i < 6; i++) tick();

    chk("final_qa_empty", qa.size(), 0);
    chk("final_qb_empty", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
